// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared types and constants for the LC-3 fetch sequencer
package lc3_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    PC_MUX_INC = 2'b00,
    PC_MUX_BUS = 2'b01,
    PC_MUX_JMP = 2'b10
  } pc_mux_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_MEM,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_timer.sv
// rtl/lc3_fetch_timer.sv - memory-wait counter with WAIT_MAX-reached flag
module lc3_fetch_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count;

  assign hit = (count == CW'(WAIT_MAX));

  // Saturates at WAIT_MAX; the FSM leaves MEM/DRAIN in that cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lc3_fetch.sv
// rtl/lc3_fetch.sv - LC-3 instruction-fetch sequencer (PC increment, memory read, IR hold)
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_go,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc_in,
  output logic              ld_pc,
  output logic [1:0]        pc_mux,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t      state, nxt;
  logic [WORD_W-1:0] mar;
  logic              tmr_clr, tmr_en, tmr_hit;
  logic              capture, timeout;

  lc3_fetch_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .hit   (tmr_hit)
  );

  // A returning word always wins over the timeout; timeout wins over flush
  // so a dead memory is not waited on again from DRAIN.
  always_comb begin
    nxt     = state;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state)
      ST_IDLE:  if (!flush && fetch_go) nxt = ST_ADDR;
      ST_ADDR:  nxt = flush ? ST_IDLE : ST_MEM;
      ST_MEM: begin
        if (mem_rdy) begin
          nxt     = flush ? ST_IDLE : ST_HOLD;
          capture = !flush;
        end else if (tmr_hit) begin
          nxt     = ST_IDLE;
          timeout = 1'b1;
        end else if (flush) begin
          nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (mem_rdy || tmr_hit) nxt = ST_IDLE;
      ST_HOLD: begin
        if (flush)       nxt = ST_IDLE;
        else if (ir_ack) nxt = fetch_go ? ST_ADDR : ST_IDLE;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  assign tmr_clr = ((nxt == ST_MEM) && (state != ST_MEM)) ||
                   ((nxt == ST_DRAIN) && (state != ST_DRAIN));
  assign tmr_en  = ((state == ST_MEM) || (state == ST_DRAIN)) && !mem_rdy;

  assign mem_addr = mar;
  assign pc_mux   = PC_MUX_INC;

  // Outputs are registered from the next state so they align with the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mar       <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ld_pc     <= 1'b0;
      mem_req   <= 1'b0;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= nxt;
      ld_pc     <= (nxt == ST_ADDR);
      mem_req   <= (nxt == ST_MEM) || (nxt == ST_DRAIN);
      busy      <= (nxt == ST_ADDR) || (nxt == ST_MEM) || (nxt == ST_DRAIN);
      ir_valid  <= (nxt == ST_HOLD);
      fetch_err <= timeout;
      if (state == ST_ADDR) mar <= pc_in;
      if (capture) begin
        ir    <= mem_rdata;
        ir_pc <= mar;
      end
    end
  end

endmodule

// File: doc/lc3_fetch.md
# lc3_fetch

Instruction-fetch sequencer for the LC-3 datapath. It sits between the PC register and the memory port. Each fetch latches the current PC as the fetch address and commands the PC register to increment (ld_pc with select 00). It then runs a request/ready read on the memory port and holds the fetched word in IR until the decode stage acknowledges it. It also supports flush (redirect) and a memory-wait timeout.

## Interface
- WAIT_MAX, 255: maximum cycles spent in MEM without mem_rdy before timeout; counter width is clog2(WAIT_MAX+1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_go  in  1  request to start one fetch; sampled in IDLE and HOLD.
- flush  in  1  discard any in-progress or held instruction; priority over fetch_go.
- pc_in  in  16  current PC value from the PC register output.
- ld_pc  out  1  PC load enable to the PC register.
- pc_mux  out  2  PC source select; driven 00 (pc+1) whenever ld_pc=1, else 00.
- mem_req  out  1  memory read request.
- mem_addr  out  16  read address (registered fetch address, MAR).
- mem_rdy  in  1  memory returns data this cycle; valid only while mem_req=1.
- mem_rdata  in  16  read data, sampled when mem_req&mem_rdy.
- ir  out  16  fetched instruction.
- ir_pc  out  16  address the held instruction was fetched from.
- ir_valid  out  1  ir/ir_pc valid for decode.
- ir_ack  in  1  decode consumed ir; meaningful only while ir_valid=1.
- busy  out  1  high in ADDR, MEM, DRAIN.
- fetch_err  out  1  one-cycle pulse on timeout.

## Operation
- States are IDLE, ADDR, MEM, DRAIN, HOLD. Moore outputs are decoded from state.
- IDLE: no outputs asserted. fetch_go moves to ADDR.
- ADDR (1 cycle): mar<=pc_in, ld_pc=1, pc_mux=00. The PC register increments at the end of this cycle. Next state is MEM, or IDLE if flush.
- MEM: mem_req=1, mem_addr=mar. The wait counter increments each cycle without mem_rdy.
  - On mem_rdy: ir<=mem_rdata, ir_pc<=mar, go to HOLD.
  - On mem_rdy with flush in the same cycle: data is discarded, go to IDLE.
  - On flush without mem_rdy: go to DRAIN. The transaction is not abandoned.
  - When the counter reaches WAIT_MAX with no mem_rdy: pulse fetch_err, drop mem_req, go to IDLE.
- DRAIN: mem_req=1 until mem_rdy, then go to IDLE. Data is discarded and ir is unchanged. The timeout also applies here, without a fetch_err pulse.
- HOLD: ir_valid=1.
  - flush: go to IDLE.
  - ir_ack with fetch_go: go to ADDR (back-to-back fetch).
  - ir_ack alone: go to IDLE.
  - Otherwise stay; ir and ir_pc remain stable.
- fetch_go outside IDLE and HOLD is ignored.
- The wait counter clears on every entry to MEM or DRAIN.
- ld_pc is never asserted outside ADDR, so PC is incremented exactly once per fetch started, including flushed fetches.

## Timing
- Reset (async, rst_n=0) puts the block in IDLE. mem_addr, ir, ir_pc and the counter are 0. ld_pc, mem_req, ir_valid, busy and fetch_err are 0. pc_mux is 00.
- Reset asserted mid-transaction drops mem_req immediately. The memory side must tolerate an abandoned request.
- Minimum latency from fetch_go (cycle 0, IDLE) to ir_valid is 3 cycles:
  - cycle 1: ADDR, ld_pc=1;
  - cycle 2: MEM, mem_req=1, mem_rdy=1;
  - cycle 3: HOLD.
- Each cycle mem_rdy is withheld adds one cycle.
- Back-to-back throughput is one instruction per 3 cycles when ir_ack and fetch_go are presented in the first HOLD cycle.
- mem_addr is stable for the whole MEM/DRAIN interval.
- Timeout fires in the cycle in which the counter equals WAIT_MAX, i.e. after WAIT_MAX+1 MEM cycles without rdy.

## Structure
- lc3_pkg holds:
  - the state enum;
  - PC_MUX_INC=2'b00, PC_MUX_BUS=2'b01, PC_MUX_JMP=2'b10;
  - the LC-3 word width constant (16).
- One sub-module, lc3_fetch_timer, holds the wait counter: clear, enable, and a WAIT_MAX-reached flag.
- Everything else is a single FSM plus the MAR/IR/ir_pc registers.

## Test plan
- Basic fetch: pc_in=0x3000, mem_rdy tied high, mem_rdata=0x1021, fetch_go pulse.
  - ld_pc=1 with pc_mux=00 in cycle 1.
  - mem_addr=0x3000 in cycle 2.
  - ir=0x1021, ir_pc=0x3000, ir_valid=1 in cycle 3.
- Wait states: mem_rdy delayed 4 cycles.
  - mem_req stays high 5 cycles with mem_addr constant.
  - ir_valid in cycle 7.
  - No fetch_err.
- Back-to-back: ir_ack and fetch_go together in the first HOLD cycle, pc_in=0x3001.
  - Second ld_pc exactly 1 cycle later.
  - Second ir_pc=0x3001.
- Flush in MEM: flush with mem_rdy low.
  - State goes to DRAIN with mem_req held.
  - rdy arrives later: ir is unchanged, ir_valid stays 0, next state IDLE.
- Timeout: WAIT_MAX=7, mem_rdy never asserted.
  - fetch_err pulses once after 8 MEM cycles.
  - mem_req drops, busy=0.
- Async reset in MEM: rst_n low mid-cycle.
  - mem_req, ir_valid and busy drop without a clock edge.
  - ir=0.
